fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each word as a UART frame:
// start bit, data LSB-first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int WIDTH_DATA = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [WIDTH_DATA-1:0] i_data,
  input  logic                  i_empty,
  output logic                  o_pop,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(WIDTH_DATA + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH_DATA - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  r_state, w_state;
  logic [BAUD_W-1:0]       r_baud, w_baud;
  logic [BIT_W-1:0]        r_bit, w_bit;
  logic [WIDTH_DATA-1:0]   r_shift, w_shift;
  logic                    r_parity, w_parity;
  logic                    r_tx, w_tx;
  logic                    r_pop, w_pop;
  logic                    r_busy, w_busy;
  logic                    w_can_load;
  logic                    w_bit_end;
  logic                    w_frame_start;

  assign w_can_load = i_enable && !i_empty;
  assign w_bit_end  = (r_baud == BAUD_LAST);

  always_comb begin
    w_state       = r_state;
    w_baud        = r_baud;
    w_bit         = r_bit;
    w_shift       = r_shift;
    w_parity      = r_parity;
    w_tx          = r_tx;
    w_pop         = 1'b0;
    w_busy        = r_busy;
    w_frame_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx          = 1'b1;
        w_busy        = 1'b0;
        w_frame_start = w_can_load;
      end
      S_START: begin
        w_baud = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud  = '0;
          w_bit   = '0;
          w_state = S_DATA;
          w_tx    = r_shift[0];
        end
      end
      S_DATA: begin
        w_baud = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud = '0;
          if (r_bit == DATA_LAST) begin
            w_bit = '0;
            if (PARITY_EN != 0) begin
              w_state = S_PARITY;
              w_tx    = r_parity;
            end else begin
              w_state = S_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit   = r_bit + 1'b1;
            w_shift = r_shift >> 1;
            w_tx    = w_shift[0];
          end
        end
      end
      S_PARITY: begin
        w_baud = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud  = '0;
          w_bit   = '0;
          w_state = S_STOP;
          w_tx    = 1'b1;
        end
      end
      S_STOP: begin
        w_baud = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud = '0;
          if (r_bit == STOP_LAST) begin
            w_bit = '0;
            // Chain straight into the next frame so the line never idles between words
            if (w_can_load) begin
              w_frame_start = 1'b1;
            end else begin
              w_state = S_IDLE;
              w_busy  = 1'b0;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase

    if (w_frame_start) begin
      w_state  = S_START;
      w_baud   = '0;
      w_bit    = '0;
      w_shift  = i_data;
      w_parity = ^i_data;
      w_tx     = 1'b0;
      w_pop    = 1'b1;
      w_busy   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_pop    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_baud   <= w_baud;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_parity <= w_parity;
      r_tx     <= w_tx;
      r_pop    <= w_pop;
      r_busy   <= w_busy;
    end
  end

  assign o_tx   = r_tx;
  assign o_pop  = r_pop;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain, parity, two stop bits)
// fed from one queue-based FIFO model and checked cycle by cycle against frame arithmetic.
module tb_fifo_uart_tx;

  localparam int CDIV = 4;
  localparam logic [2:0] PAR_MASK   = 3'b010;
  localparam logic [2:0] STOP2_MASK = 3'b100;

  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic [7:0] tb_data;
  logic       tb_empty;
  int         sel;
  logic [2:0] w_empty;
  logic [2:0] pop, tx, busy;

  logic [7:0] fq[$];
  int         pop_cnt;
  int         underflow;
  int         n_chk;
  int         n_pass;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign w_empty[gi] = tb_empty || (sel != gi);
    fifo_uart_tx #(
      .WIDTH_DATA(8),
      .CLK_DIV   (CDIV),
      .PARITY_EN (int'(PAR_MASK[gi])),
      .STOP_BITS (1 + int'(STOP2_MASK[gi]))
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_enable(en[gi]),
      .i_data  (tb_data),
      .i_empty (w_empty[gi]),
      .o_pop   (pop[gi]),
      .o_tx    (tx[gi]),
      .o_busy  (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh();
    tb_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    tb_empty = (fq.size() == 0);
  endtask

  // FIFO model: a pop strobe seen mid-cycle retires the head word
  always @(negedge clk) begin
    if (pop[sel]) begin
      if (fq.size() == 0) underflow++;
      else void'(fq.pop_front());
      pop_cnt++;
      refresh();
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int flen(input int d);
    return (1 + 8 + int'(PAR_MASK[d]) + 1 + int'(STOP2_MASK[d])) * CDIV;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int d);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && PAR_MASK[d]) return ^b;
    return 1'b1;
  endfunction

  // Sends whatever is queued on instance d; expected line derived from frame layout
  task automatic run_case(input string tag, input int d, input int extra, input int drop_at);
    logic [7:0] exp_q[$];
    logic [2:0] obs, expv;
    int L, nfr, total, f, k;
    exp_q = fq;
    L     = flen(d);
    nfr   = exp_q.size();
    if (drop_at >= 0 && (drop_at / L + 1) < nfr) nfr = drop_at / L + 1;
    total = nfr * L + extra;
    pop_cnt = 0;
    sel = d;
    refresh();
    en[d] = 1'b1;
    for (int s = 0; s < total; s++) begin
      @(negedge clk);
      if (s < nfr * L) begin
        f = s / L;
        k = (s % L) / CDIV;
        expv = {exp_bit(exp_q[f], k, d), 1'b1, ((s % L) == 0)};
      end else begin
        expv = 3'b100;
      end
      obs = {tx[d], busy[d], pop[d]};
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s cycle=%0d tx/busy/pop observed=%b expected=%b", tag, s, obs, expv);
      if (s == drop_at) en[d] = 1'b0;
    end
    en[d] = 1'b0;
    chk({tag, "_pops"}, pop_cnt, nfr);
    chk({tag, "_fifo_left"}, fq.size(), exp_q.size() - nfr);
    $display("case %s dut=%0d frames=%0d cycles=%0d", tag, d, nfr, total);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; pop_cnt = 0; underflow = 0;
    rst_n = 1'b0; en = 3'b000; sel = 0;
    refresh();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_out", int'({tx[d], busy[d], pop[d]}), 3'b100);
    rst_n = 1'b1;
    @(negedge clk);

    fq.push_back(8'hA5);
    run_case("single_a5", 0, 8, -1);

    fq.push_back(8'h01); fq.push_back(8'h80); fq.push_back(8'hFF);
    run_case("back2back", 0, 8, -1);

    fq.push_back(8'h07);
    run_case("parity_07", 1, 8, -1);
    fq.push_back(8'h03);
    run_case("parity_03", 1, 8, -1);

    fq.push_back(8'h55);
    run_case("stop2_55", 2, 8, -1);

    run_case("idle_empty", 0, 100, -1);

    fq.push_back(8'h3C); fq.push_back(8'hC3);
    run_case("enable_drop", 0, 30, 10);
    fq.delete();
    refresh();

    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 2; r++) begin
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom_range(0, 255)));
        run_case("random", d, 6, -1);
      end
    end

    // Reset asserted during data bit 3 of the first word
    fq.push_back(8'hA5); fq.push_back(8'h3C);
    sel = 0;
    refresh();
    en[0] = 1'b1;
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", int'({tx[0], busy[0], pop[0]}), 3'b100);
    en[0] = 1'b0;
    @(negedge clk);
    chk("rst_hold", int'({tx[0], busy[0], pop[0]}), 3'b100);
    chk("rst_fifo_left", fq.size(), 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_case("rst_recover", 0, 8, -1);

    chk("underflow", underflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
